// File: rtl/mult_div_e.sv
// Execute-stage multiply/divide unit: multi-cycle mult/div into HI/LO, plus mthi/mtlo/mfhi/mflo.
// Busy is registered; the hazard unit combines it with Start to stall HI/LO consumers.
module mult_div_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [3:0]  MDop,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDout
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [31:0]     a_q;
  logic [31:0]     b_q;
  logic [3:0]      op_q;
  logic [31:0]     hi_q;
  logic [31:0]     lo_q;
  logic            busy_q;

  logic            start_ok;
  logic            is_div;
  logic [63:0]     prod_s;
  logic [63:0]     prod_u;
  logic [31:0]     quot_s;
  logic [31:0]     rem_s;
  logic [31:0]     quot_u;
  logic [31:0]     rem_u;

  assign start_ok = Start && (MDop >= OP_MULT) && (MDop <= OP_DIVU);
  assign is_div   = (MDop == OP_DIV) || (MDop == OP_DIVU);

  // Datapath works on the latched operands, so forwarding changes during RUN do not matter.
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};
  assign quot_s = $signed(a_q) / $signed(b_q);
  assign rem_s  = $signed(a_q) % $signed(b_q);
  assign quot_u = a_q / b_q;
  assign rem_u  = a_q % b_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            a_q    <= SrcA;
            b_q    <= SrcB;
            op_q   <= MDop;
            cnt    <= is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
            busy_q <= 1'b1;
            state  <= RUN;
          end else if (MDop == OP_MTHI) begin
            hi_q <= SrcA;
          end else if (MDop == OP_MTLO) begin
            lo_q <= SrcA;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            case (op_q)
              OP_MULT:  {hi_q, lo_q} <= prod_s;
              OP_MULTU: {hi_q, lo_q} <= prod_u;
              OP_DIV: begin
                // A zero divisor still burns the full busy period but leaves HI/LO alone.
                if (b_q != '0) begin
                  hi_q <= rem_s;
                  lo_q <= quot_s;
                end
              end
              OP_DIVU: begin
                if (b_q != '0) begin
                  hi_q <= rem_u;
                  lo_q <= quot_u;
                end
              end
              default: ;
            endcase
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Busy  = busy_q;
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign MDout = (MDop == OP_MFHI) ? hi_q : lo_q;

endmodule

// File: doc/mult_div_e.md
# mult_div_e

Execute-stage multiply/divide unit, operating beside `alu_E` on the same forwarded `SrcA`/`SrcB` operands. It executes mult, multu, div and divu over several cycles and holds the results in architectural HI/LO registers. It also services mthi, mtlo, mfhi and mflo. It drives `Busy` so the hazard unit can stall later HI/LO-dependent instructions in D.

## Interface
- `MULT_CYCLES`, default 5: cycles `Busy` stays high for mult/multu.
- `DIV_CYCLES`, default 10: cycles `Busy` stays high for div/divu.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `SrcA` in 32: rs operand (dividend / multiplicand / mthi-mtlo data).
- `SrcB` in 32: rt operand (divisor / multiplier).
- `MDop` in 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo. Codes 9–15 behave as none.
- `Start` in 1: one-cycle pulse, valid only with `MDop` 1–4.
- `Busy` out 1: computation in progress.
- `HI` out 32: architectural HI.
- `LO` out 32: architectural LO.
- `MDout` out 32: combinational read; `HI` when `MDop`=7, else `LO`.

## Operation
- Two states, IDLE and RUN, with a down-counter `cnt`.
- **IDLE → RUN:**
  - Transition on a posedge with `Start`=1 and `MDop` in 1–4.
  - On that edge, latch `SrcA`, `SrcB` and the op into internal registers.
  - Load `cnt` with `MULT_CYCLES`-1 or `DIV_CYCLES`-1.
- **RUN:**
  - `cnt` decrements each edge.
  - On the edge where `cnt`=0, write HI/LO from the latched operands and return to IDLE.
- **Arithmetic:**
  - mult: {HI,LO} = $signed(A)*$signed(B), full 64-bit product.
  - multu: {HI,LO} = A*B, unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend.
  - divu: unsigned quotient to LO, unsigned remainder to HI.
- **Divide by zero** (latched B = 0): the full `DIV_CYCLES` busy period still occurs; HI and LO remain unchanged at completion.
- **mthi / mtlo:** on the posedge with `MDop` 5/6 and state IDLE, write `SrcA` to HI/LO. Other register unchanged.
- **Ignored ops:**
  - `Start`, mthi and mtlo arriving while in RUN are ignored.
  - The hazard unit guarantees this never happens; the block must still not corrupt state if it does.
- **`Start` with `MDop` not in 1–4:** ignored.
- **Reads:** `MDout` reflects current HI/LO even during RUN (stale value). Stalling such reads is the hazard unit's job.
- **Reset (asserted any time, including mid-RUN):**
  - HI=0, LO=0, `Busy`=0, `cnt`=0, state IDLE.
  - Latched operands cleared; the in-flight operation is discarded.

## Timing
- `Start` sampled at edge T0. `Busy`=1 from just after T0 until just after edge T0+N (N = `MULT_CYCLES` or `DIV_CYCLES`). That is exactly N cycles high.
- HI/LO take new values at edge T0+N, the same edge where `Busy` falls.
- `Busy` is registered. The hazard unit must OR `Start` with `Busy` to stall the instruction that immediately follows.
- A new `Start` is accepted at edge T0+N+1 at the earliest, i.e. back-to-back with no dead cycle after `Busy` falls.
- mthi/mtlo: zero latency; HI/LO update at the sampling edge.
- `MDout`: combinational from HI/LO and `MDop`; no added latency.
- Reset outputs: `Busy`=0, HI=0, LO=0, `MDout`=0.

## Test plan
- **Reset:** assert `reset` mid-cycle with no clock edge → `HI`=`LO`=`MDout`=0 and `Busy`=0 immediately.
- **Signed vs unsigned multiply:**
  - mult with `SrcA`=`SrcB`=0xffffffff → `Busy` high 5 cycles, then HI=0x00000000, LO=0x00000001.
  - Same operands with multu → HI=0xfffffffe, LO=0x00000001.
- **Signed vs unsigned divide:**
  - div with 0xfffffff9 / 0x00000002 → after 10 cycles LO=0xfffffffd, HI=0xffffffff.
  - divu with the same operands → LO=0x7ffffffc, HI=0x00000001.
- **Divide by zero:** preload HI=0x12345678 and LO=0x9abcdef0 via mthi/mtlo, then div by 0 → `Busy` high 10 cycles, HI/LO unchanged afterwards.
- **Ops during RUN are ignored:** during a mult of 3*4, pulse `Start` with div 100/7 and issue mthi 0xdeadbeef → final HI=0, LO=0x0000000c; `Busy` falls exactly 5 cycles after the first `Start`.
- **Reset mid-operation:**
  - Assert `reset` 3 cycles into a div → `Busy`=0 and HI=LO=0 at once.
  - After release, a new multu 2*3 completes with LO=6.
